// File: rtl/clock_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_monitor
// Brief    : Synchronises a slow free-running clock into clk_i, emits a tick
//            per rising edge, measures period and high time, and reports lock
//            to an expected period plus a sticky stall timeout.
//            Optional duty-cycle check: define CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
//            to add duty_err_o and fold duty tolerance into lock.
// Revision : 1.0 - initial release
// ============================================================================
module clock_period_monitor #(
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 100000000,
    parameter int TOL         = 16,
    parameter int TIMEOUT     = 200000000
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             sig_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid_o,
    output logic             locked_o,
    output logic             timeout_o
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    ,
    output logic             duty_err_o
`endif
);

    // Lock window bounds, clamped into the unsigned counter range.
    localparam longint c_max    = (longint'(1) << CNT_W) - 1;
    localparam longint c_lo_raw = longint'(EXP_PERIOD) - longint'(TOL);
    localparam longint c_hi_raw = longint'(EXP_PERIOD) + longint'(TOL);
    localparam longint c_lo_l   = (c_lo_raw < 0) ? 0 : c_lo_raw;
    localparam longint c_hi_l   = (c_hi_raw > c_max) ? c_max : c_hi_raw;
    localparam logic [CNT_W-1:0] c_win_lo  = CNT_W'(c_lo_l);
    localparam logic [CNT_W-1:0] c_win_hi  = CNT_W'(c_hi_l);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_cap;
    logic                   r_fall_seen;
    logic [1:0]             r_match;

    logic w_sync_out;
    logic w_rise;
    logic w_fall;
    logic w_meas;
    logic w_timeout_evt;
    logic w_in_win;
    logic w_match_ok;
    logic [CNT_W-1:0] w_high_eff;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_hist;
    assign w_fall     = ~w_sync_out & r_hist;
    assign w_meas     = w_rise && (r_state == S_MEASURE);
    assign w_in_win   = (r_cnt >= c_win_lo) && (r_cnt <= c_win_hi);
    // A rise with no fall since the previous rise reports the full period as high time.
    assign w_high_eff = r_fall_seen ? r_high_cap : r_cnt;

`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    logic [CNT_W:0] w_twice_high;
    logic [CNT_W:0] w_per_ext;
    logic [CNT_W:0] w_duty_diff;
    logic           w_duty_bad;

    assign w_twice_high = {w_high_eff, 1'b0};
    assign w_per_ext    = {1'b0, r_cnt};
    assign w_duty_diff  = (w_twice_high >= w_per_ext) ? (w_twice_high - w_per_ext)
                                                      : (w_per_ext - w_twice_high);
    assign w_duty_bad   = w_duty_diff > (CNT_W+1)'(TOL);
    assign w_match_ok   = w_in_win && !w_duty_bad;

    // Duty error refreshes alongside every completed measurement.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            duty_err_o <= 1'b0;
        end else if (w_meas) begin
            duty_err_o <= w_duty_bad;
        end
    end
`else
    assign w_match_ok = w_in_win;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a rise always wins over a coincident timeout.
    always_comb begin
        w_state_next  = r_state;
        w_timeout_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!w_rise && (r_cnt == c_timeout)) begin
                    w_state_next  = S_IDLE;
                    w_timeout_evt = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Synchroniser chain, edge history and the tick strobe.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_hist <= w_sync_out;
            tick_o <= w_rise;
        end
    end

    // Free-running saturating cycle counter, restarted at 1 on each rise.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // High-time capture and publishing of completed measurements.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_high_cap   <= '0;
            r_fall_seen  <= 1'b0;
            period_o     <= '0;
            high_o       <= '0;
            meas_valid_o <= 1'b0;
        end else begin
            meas_valid_o <= w_meas;
            if (w_rise) begin
                r_fall_seen <= 1'b0;
            end else if (w_fall && (r_state == S_MEASURE)) begin
                r_fall_seen <= 1'b1;
                r_high_cap  <= r_cnt;
            end
            if (w_meas) begin
                period_o <= r_cnt;
                high_o   <= w_high_eff;
            end
        end
    end

    // Lock tracking and the sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_match   <= 2'd0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else if (w_timeout_evt) begin
            r_match   <= 2'd0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b1;
        end else begin
            locked_o <= (r_match == 2'd2);
            if (w_rise) begin
                timeout_o <= 1'b0;
            end
            if (w_meas) begin
                if (w_match_ok) begin
                    r_match <= (r_match == 2'd2) ? 2'd2 : r_match + 2'd1;
                end else begin
                    r_match <= 2'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_period_monitor
// Brief    : Directed bench for clock_period_monitor with an event-level
//            reference model compared every cycle, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_period_monitor;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int EXP_PERIOD  = 10;
    localparam int TOL         = 1;
    localparam int TIMEOUT     = 40;

    logic             clk_i;
    logic             reset;
    logic             sig_i;
    logic             tick_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid_o;
    logic             locked_o;
    logic             timeout_o;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    logic             duty_err_o;
`endif

    int checks = 0;
    int passed = 0;

    clock_period_monitor #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .sig_i       (sig_i),
        .tick_o      (tick_o),
        .period_o    (period_o),
        .high_o      (high_o),
        .meas_valid_o(meas_valid_o),
        .locked_o    (locked_o),
        .timeout_o   (timeout_o)
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
        ,
        .duty_err_o  (duty_err_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on the sequence of sig_i values sampled at
    // each clk_i edge. A rising edge in that sequence at sample k is
    // judged SYNC_STAGES edges later; periods and high times are plain
    // differences of sample indices.
    // ------------------------------------------------------------------
    bit v [0:8191];
    int n = 16;
    int rise_k = 0;
    int fall_k = 0;
    int streak = 0;
    bit measuring = 0;
    bit model_ready = 0;
    bit e_tick, e_valid, e_locked, e_timeout, e_duty;
    int e_period, e_high;

    always @(posedge clk_i) begin
        int k;
        int prev_streak;
        bit rise, fall, ok;
        n++;
        v[n] = sig_i;
        if (reset) begin
            v[n] = 0; v[n-1] = 0; v[n-2] = 0;
            measuring = 0; streak = 0;
            e_tick = 0; e_valid = 0; e_locked = 0; e_timeout = 0; e_duty = 0;
            e_period = 0; e_high = 0;
            rise_k = 0; fall_k = 0;
        end else begin
            k = n - SYNC_STAGES;
            rise = v[k] && !v[k-1];
            fall = !v[k] && v[k-1];
            prev_streak = streak;
            e_tick  = rise;
            e_valid = 0;
            if (fall) fall_k = k;
            if (rise) begin
                if (measuring) begin
                    e_valid  = 1;
                    e_period = k - rise_k;
                    e_high   = (fall_k > rise_k) ? fall_k - rise_k : e_period;
                    ok = (e_period >= EXP_PERIOD - TOL) && (e_period <= EXP_PERIOD + TOL);
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
                    e_duty = ((2*e_high > e_period) ? 2*e_high - e_period
                                                    : e_period - 2*e_high) > TOL;
                    if (e_duty) ok = 0;
`endif
                    streak = ok ? streak + 1 : 0;
                end
                measuring = 1;
                rise_k    = k;
                e_timeout = 0;
                e_locked  = (prev_streak >= 2);
            end else if (measuring && (k - rise_k) == TIMEOUT) begin
                measuring = 0;
                streak    = 0;
                e_timeout = 1;
                e_locked  = 0;
            end else begin
                e_locked = (prev_streak >= 2);
            end
        end
        model_ready = 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (model_ready) begin
            chk("tick_o",       {31'd0, tick_o},       {31'd0, e_tick});
            chk("meas_valid_o", {31'd0, meas_valid_o}, {31'd0, e_valid});
            chk("locked_o",     {31'd0, locked_o},     {31'd0, e_locked});
            chk("timeout_o",    {31'd0, timeout_o},    {31'd0, e_timeout});
            chk("period_o",     {24'd0, period_o},     e_period);
            chk("high_o",       {24'd0, high_o},       e_high);
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
            chk("duty_err_o",   {31'd0, duty_err_o},   {31'd0, e_duty});
`endif
        end
    end

    // Drive cnt full periods of sig_i with the given period and high time.
    task automatic run(input int p, input int h, input int cnt);
        for (int c = 0; c < cnt; c++) begin
            for (int j = 0; j < p; j++) begin
                sig_i = (j < h);
                @(negedge clk_i);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " tick"},   {31'd0, tick_o},       32'd0);
        chk({tag, " valid"},  {31'd0, meas_valid_o}, 32'd0);
        chk({tag, " period"}, {24'd0, period_o},     32'd0);
        chk({tag, " high"},   {24'd0, high_o},       32'd0);
        chk({tag, " locked"}, {31'd0, locked_o},     32'd0);
        chk({tag, " tmo"},    {31'd0, timeout_o},    32'd0);
    endtask

    initial begin
        reset = 1'b1;
        sig_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset = 1'b0;
        chk_all_zero("reset");

        // Tick latency: sig_i high sampled at edge 1, tick visible after edge 3.
        sig_i = 1'b1;
        @(negedge clk_i); chk("lat e1 tick", {31'd0, tick_o}, 32'd0);
        @(negedge clk_i); chk("lat e2 tick", {31'd0, tick_o}, 32'd0);
        @(negedge clk_i); chk("lat e3 tick", {31'd0, tick_o}, 32'd1);
        repeat (2) @(negedge clk_i);
        sig_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Nominal 10/5 clock.
        run(10, 5, 4);
        chk("nom period", {24'd0, period_o}, 32'd10);
        chk("nom high",   {24'd0, high_o},   32'd5);
        chk("nom locked", {31'd0, locked_o}, 32'd1);

        // Reset mid-run after lock.
        reset = 1'b1;
        @(negedge clk_i);
        reset = 1'b0;
        chk_all_zero("midreset");
        run(10, 5, 3);
        chk("relock locked", {31'd0, locked_o}, 32'd1);

        // Out of window, then back.
        run(13, 6, 3);
        chk("oow period", {24'd0, period_o}, 32'd13);
        chk("oow locked", {31'd0, locked_o}, 32'd0);
        run(10, 5, 3);
        chk("back locked", {31'd0, locked_o}, 32'd1);

        // Stall: sig_i held low past TIMEOUT.
        sig_i = 1'b0;
        repeat (50) @(negedge clk_i);
        chk("stall tmo",    {31'd0, timeout_o}, 32'd1);
        chk("stall locked", {31'd0, locked_o},  32'd0);
        run(10, 5, 3);
        chk("post stall tmo", {31'd0, timeout_o}, 32'd0);

        // Glitch-width high phase.
        run(10, 1, 4);
        chk("glitch period", {24'd0, period_o}, 32'd10);
        chk("glitch high",   {24'd0, high_o},   32'd1);
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
        chk("glitch duty",   {31'd0, duty_err_o}, 32'd1);
        chk("glitch locked", {31'd0, locked_o},   32'd0);
`endif

        // Rise lands exactly when the counter reaches TIMEOUT.
        run(40, 5, 2);
        chk("race period", {24'd0, period_o},  32'd40);
        chk("race tmo",    {31'd0, timeout_o}, 32'd0);

        repeat (5) @(negedge clk_i);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
